// File: rtl/spike_window_classifier_if.sv
// Result handshake bundle for spike_window_classifier.
// Carries the class decision and window totals to the readout side.
interface spike_window_classifier_if #(
    parameter int CW = 6
) ();
    logic          class_valid;
    logic          class_ready;
    logic [1:0]    class_id;
    logic [CW-1:0] tot_a;
    logic [CW-1:0] tot_b;

    modport master (
        output class_valid,
        output class_id,
        output tot_a,
        output tot_b,
        input  class_ready
    );

    modport slave (
        input  class_valid,
        input  class_id,
        input  tot_a,
        input  tot_b,
        output class_ready
    );
endinterface

// File: rtl/spike_window_classifier.sv
// Windowed rate decoder for group-gated WTA spikes.
// Counts Group A/B spikes per window and reports the winning class.
module spike_window_classifier #(
    parameter int WINDOW = 16,
    parameter int THRESH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [3:0]                   spike_in,
    spike_window_classifier_if.master    res,
    output logic                         overrun
);
    localparam int CW = $clog2(2*WINDOW+1);
    localparam int WW = $clog2(WINDOW);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] win_cnt, win_nx;
    logic [CW-1:0] acc_a, acc_b, acc_a_nx, acc_b_nx;
    logic [CW-1:0] fa, fb;
    logic          done;
    logic [1:0]    cls;

    logic          valid;
    logic [1:0]    id_r;
    logic [CW-1:0] ta_r, tb_r;

    // Next state, running totals including this cycle, and window end.
    always_comb begin
        state_nx = state;
        win_nx   = '0;
        acc_a_nx = '0;
        acc_b_nx = '0;
        done     = 1'b0;
        fa = ((state == RUN) ? acc_a : '0)
           + CW'(spike_in[0]) + CW'(spike_in[1]);
        fb = ((state == RUN) ? acc_b : '0)
           + CW'(spike_in[2]) + CW'(spike_in[3]);
        unique case (state)
            IDLE:    if (en)  state_nx = RUN;
            RUN:     if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // en=0 leaves the defaults: partial window is discarded.
        if (en) begin
            if (win_cnt == WW'(WINDOW-1)) begin
                done = 1'b1;
            end else begin
                win_nx   = win_cnt + 1'b1;
                acc_a_nx = fa;
                acc_b_nx = fb;
            end
        end
    end

    // Decide the class from the final totals of the window.
    always_comb begin
        cls = 2'd0;
        if (fa > fb && fa >= CW'(THRESH)) begin
            cls = 2'd1;
        end else if (fb > fa && fb >= CW'(THRESH)) begin
            cls = 2'd2;
        end
    end

    // State, window counter and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
        end else begin
            state   <= state_nx;
            win_cnt <= win_nx;
            acc_a   <= acc_a_nx;
            acc_b   <= acc_b_nx;
        end
    end

    // Single-entry result buffer; a result arriving while blocked is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            id_r    <= 2'd0;
            ta_r    <= '0;
            tb_r    <= '0;
            overrun <= 1'b0;
        end else if (done) begin
            if (!valid || res.class_ready) begin
                valid <= 1'b1;
                id_r  <= cls;
                ta_r  <= fa;
                tb_r  <= fb;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && res.class_ready) begin
            valid <= 1'b0;
        end
    end

    assign res.class_valid = valid;
    assign res.class_id    = id_r;
    assign res.tot_a       = ta_r;
    assign res.tot_b       = tb_r;
endmodule

// File: tb/tb_spike_window_classifier.sv
// Self-checking bench for spike_window_classifier (WINDOW=4, THRESH=3).
// Table-driven windows plus hand-written handshake/abort/reset sequences.
module tb_spike_window_classifier;
    localparam int WINDOW = 4;
    localparam int THRESH = 3;
    localparam int CW     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] spike_in = 4'b0000;
    logic       overrun;

    spike_window_classifier_if #(.CW(CW)) res_if ();

    spike_window_classifier #(
        .WINDOW(WINDOW),
        .THRESH(THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .spike_in(spike_in),
        .res(res_if),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        int         ta;
        int         tb;
        int         at;
    } exp_t;

    typedef struct {
        logic [3:0] s0;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [1:0] id;
        int         ta;
        int         tb;
    } vec_t;

    exp_t q[$];
    exp_t got;
    vec_t vt[10];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic step(input logic e, input logic [3:0] s);
        en = e;
        spike_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input int ta,
                        input int tb, input bit timed);
        exp_t e;
        e.id = id;
        e.ta = ta;
        e.tb = tb;
        e.at = timed ? cyc : -1;
        q.push_back(e);
    endtask

    // Scoreboard: every transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && res_if.class_valid && res_if.class_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_transfer: id=%0d a=%0d b=%0d cycle %0d",
                         res_if.class_id, res_if.tot_a, res_if.tot_b, cyc);
            end else begin
                got = q.pop_front();
                chk("class_id", int'(res_if.class_id), int'(got.id));
                chk("tot_a", int'(res_if.tot_a), got.ta);
                chk("tot_b", int'(res_if.tot_b), got.tb);
                if (got.at >= 0) chk("latency_cycle", cyc, got.at);
            end
        end
    end

    initial begin
        vt[0] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 2'd1, 8, 0};
        vt[1] = '{4'b0001, 4'b1100, 4'b0001, 4'b1100, 2'd2, 2, 4};
        vt[2] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 2'd0, 2, 2};
        vt[3] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1, 0};
        vt[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0};
        vt[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 2'd0, 8, 8};
        vt[6] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 2'd1, 3, 0};
        vt[7] = '{4'b1100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 3};
        vt[8] = '{4'b0011, 4'b1100, 4'b0100, 4'b0000, 2'd2, 2, 3};
        vt[9] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 2'd0, 1, 2};

        res_if.class_ready = 1'b1;
        rst = 1'b1;
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        rst = 1'b0;
        step(1'b0, 4'b0000);
        chk("reset_valid", int'(res_if.class_valid), 0);
        chk("reset_id", int'(res_if.class_id), 0);
        chk("reset_tot_a", int'(res_if.tot_a), 0);
        chk("reset_tot_b", int'(res_if.tot_b), 0);
        chk("reset_overrun", int'(overrun), 0);

        // Back-to-back windows, ready held high.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vt[i].s0);
            step(1'b1, vt[i].s1);
            step(1'b1, vt[i].s2);
            step(1'b1, vt[i].s3);
            push(vt[i].id, vt[i].ta, vt[i].tb, 1'b1);
        end
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        chk("pulse_low", int'(res_if.class_valid), 0);

        // Transfer on the wrap cycle: new result loads, valid stays high.
        res_if.class_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0011);
        push(2'd1, 8, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1100);
        chk("held_valid", int'(res_if.class_valid), 1);
        res_if.class_ready = 1'b1;
        step(1'b1, 4'b1100);
        push(2'd2, 0, 8, 1'b1);
        chk("wrap_xfer_valid", int'(res_if.class_valid), 1);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        chk("wrap_no_overrun", int'(overrun), 0);

        // Blocked consumer: second window dropped, overrun set.
        res_if.class_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0011);
        push(2'd1, 8, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0011);
        chk("ovr_valid", int'(res_if.class_valid), 1);
        chk("ovr_hold_id", int'(res_if.class_id), 1);
        chk("ovr_hold_a", int'(res_if.tot_a), 8);
        chk("ovr_hold_b", int'(res_if.tot_b), 0);
        chk("ovr_flag", int'(overrun), 1);
        res_if.class_ready = 1'b1;
        step(1'b1, 4'b0011);
        chk("ovr_fall", int'(res_if.class_valid), 0);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0011);
        push(2'd1, 8, 0, 1'b1);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        chk("ovr_sticky", int'(overrun), 1);

        // Abort mid-window: no result, nothing carried over.
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0011);
        step(1'b0, 4'b0011);
        step(1'b0, 4'b0000);
        chk("abort_no_valid", int'(res_if.class_valid), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1100);
        push(2'd2, 0, 8, 1'b1);
        step(1'b0, 4'b0000);

        // Reset while a result is pending and mid-window.
        res_if.class_ready = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 4'b0011);
        chk("pre_rst_valid", int'(res_if.class_valid), 1);
        rst = 1'b1;
        step(1'b1, 4'b0011);
        rst = 1'b0;
        chk("rst_valid", int'(res_if.class_valid), 0);
        chk("rst_id", int'(res_if.class_id), 0);
        chk("rst_tot_a", int'(res_if.tot_a), 0);
        chk("rst_tot_b", int'(res_if.tot_b), 0);
        chk("rst_overrun", int'(overrun), 0);
        res_if.class_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1100);
        push(2'd2, 0, 8, 1'b1);
        step(1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);

        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end
endmodule
